// File: rtl/williams_blitter_q_pkg.sv
// Shared encodings for the queued blitter: FSM states, register map,
// control-bit positions and the command bundle held in shadow/pending/active.
package williams_blitter_q_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_HALT = 2'd1,
    ST_SRC       = 2'd2,
    ST_DST       = 2'd3
  } state_e;

  localparam logic [3:0] RS_CTRL   = 4'd0;
  localparam logic [3:0] RS_SOLID  = 4'd1;
  localparam logic [3:0] RS_SRC_HI = 4'd2;
  localparam logic [3:0] RS_SRC_LO = 4'd3;
  localparam logic [3:0] RS_DST_HI = 4'd4;
  localparam logic [3:0] RS_DST_LO = 4'd5;
  localparam logic [3:0] RS_WIDTH  = 4'd6;
  localparam logic [3:0] RS_HEIGHT = 4'd7;
  localparam logic [3:0] RS_STATUS = 4'd8;
  localparam logic [3:0] RS_KEY    = 4'd9;
  localparam logic [3:0] RS_ABORT  = 4'd10;

  localparam int CB_SPAN_SRC  = 0;
  localparam int CB_SPAN_DST  = 1;
  localparam int CB_SLOW      = 2;
  localparam int CB_FG        = 3;
  localparam int CB_SOLID     = 4;
  localparam int CB_SHIFT     = 5;
  localparam int CB_MASK_EVEN = 6;
  localparam int CB_MASK_ODD  = 7;

  typedef struct packed {
    logic [7:0]  ctrl;
    logic [7:0]  solid;
    logic [15:0] src;
    logic [15:0] dst;
    logic [7:0]  width;
    logic [7:0]  height;
    logic [3:0]  key;
  } blit_t;

endpackage

// File: rtl/williams_blitter_q_pixel_path.sv
// Pixel path: source word latch with one-pixel shift carry, solid colour
// replication, transparent-key compare and per-pixel write enables.
// Ports: clk/rst_n/en_i, load_i (src beat), clr_i (carry clear), ctrl
// flags, solid_i, key_i, data_i (bus read) -> data_o, nib_en_o.
module williams_blt_pixel_path #(
  parameter  int PIX_PER_WORD = 2,
  localparam int DATA_W       = 4 * PIX_PER_WORD
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic                    load_i,
  input  logic                    clr_i,
  input  logic                    shift_i,
  input  logic                    solid_en_i,
  input  logic                    fg_i,
  input  logic                    mask_even_i,
  input  logic                    mask_odd_i,
  input  logic                    halt_ack_i,
  input  logic                    src_i,
  input  logic [7:0]              solid_i,
  input  logic [3:0]              key_i,
  input  logic [DATA_W-1:0]       data_i,
  output logic [DATA_W-1:0]       data_o,
  output logic [PIX_PER_WORD-1:0] nib_en_o
);

  logic [DATA_W-1:0] word_q;
  logic [3:0]        carry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      carry_q <= '0;
    end else if (en_i) begin
      if (clr_i) carry_q <= '0;
      if (load_i) begin
        // shifted word: previous low pixel enters at the top
        word_q <= shift_i ? DATA_W'({carry_q, data_i} >> 4)
                          : data_i;
        if (shift_i) carry_q <= data_i[3:0];
      end
    end
  end

  for (genvar i = 0; i < PIX_PER_WORD; i++) begin : g_pix
    logic [3:0] pix;
    logic       msk;
    assign pix = solid_en_i ? solid_i[4*(i%2) +: 4]
                            : word_q[4*i +: 4];
    assign msk = (i % 2 == 0) ? mask_even_i : mask_odd_i;
    assign data_o[4*i +: 4] = pix;
    assign nib_en_o[i] = !halt_ack_i || src_i ||
                         !(msk || (fg_i && pix == key_i));
  end

endmodule

// File: rtl/williams_blitter_q.sv
// Queued DMA blitter: shadow regs, one-entry pending slot, copy/fill FSM.
// Ports: CPU reg bus (reg_cs/reg_wr/rs/data), halt/halt_ack, blitter bus
// (blt_rd/wr/address/data/nibble_en/ack) and a done pulse.
module williams_blitter_q
  import williams_blitter_q_pkg::*;
#(
  parameter  int IS_SC1       = 1,
  parameter  int ADDR_W       = 16,
  parameter  int PIX_PER_WORD = 2,
  parameter  int SPAN_STRIDE  = 256,
  localparam int DATA_W       = 4 * PIX_PER_WORD
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_e_n,
  input  logic                    reg_cs,
  input  logic                    reg_wr,
  input  logic [3:0]              rs,
  input  logic [7:0]              reg_data_in,
  output logic [7:0]              reg_data_out,
  output logic                    halt,
  input  logic                    halt_ack,
  input  logic                    blt_ack,
  output logic                    blt_rd,
  output logic                    blt_wr,
  output logic [ADDR_W-1:0]       blt_address_out,
  input  logic [DATA_W-1:0]       blt_data_in,
  output logic [DATA_W-1:0]       blt_data_out,
  output logic [PIX_PER_WORD-1:0] blt_nibble_en,
  output logic                    done
);

  state_e            state_q;
  blit_t             shd_q, pend_q, act_q, cmd_d;
  logic              pend_v_q, ovf_q, done_q;
  logic [ADDR_W-1:0] src_q, dst_q, src_d, dst_d;
  logic [7:0]        x_q, y_q;

  logic wr_en, commit, abort, stat_rd;
  logic row_end, last_row, xfer_end, launch;
  logic [7:0] sz_d;
  logic unused_ok;

  assign wr_en   = reg_cs && reg_wr;
  assign commit  = wr_en && rs == RS_CTRL;
  assign abort   = en_e_n && wr_en && rs == RS_ABORT;
  assign stat_rd = reg_cs && !reg_wr && rs == RS_STATUS;
  assign sz_d    = (IS_SC1 != 0) ? reg_data_in ^ 8'h04 : reg_data_in;
  assign unused_ok = act_q.ctrl[CB_SLOW];

  // 8-bit wrap makes a size of 0 behave as 256
  assign row_end  = x_q == act_q.width - 8'd1;
  assign last_row = y_q == act_q.height - 8'd1;
  assign xfer_end = state_q == ST_DST && blt_ack && row_end && last_row;
  assign launch   = pend_v_q && !abort &&
                    (state_q == ST_IDLE || xfer_end);

  always_comb begin
    cmd_d      = shd_q;
    cmd_d.ctrl = reg_data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shd_q    <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (en_e_n) begin
      if (wr_en) begin
        case (rs)
          RS_CTRL:   shd_q.ctrl       <= reg_data_in;
          RS_SOLID:  shd_q.solid      <= reg_data_in;
          RS_SRC_HI: shd_q.src[15:8]  <= reg_data_in;
          RS_SRC_LO: shd_q.src[7:0]   <= reg_data_in;
          RS_DST_HI: shd_q.dst[15:8]  <= reg_data_in;
          RS_DST_LO: shd_q.dst[7:0]   <= reg_data_in;
          RS_WIDTH:  shd_q.width      <= sz_d;
          RS_HEIGHT: shd_q.height     <= sz_d;
          RS_KEY:    shd_q.key        <= reg_data_in[3:0];
          default: ;
        endcase
      end
      if (stat_rd) ovf_q <= 1'b0;
      // a launch in the same enable frees the slot for the new commit
      if (abort) begin
        pend_v_q <= 1'b0;
      end else if (commit && (!pend_v_q || launch)) begin
        pend_q   <= cmd_d;
        pend_v_q <= 1'b1;
      end else if (commit) begin
        ovf_q <= 1'b1;
      end else if (launch) begin
        pend_v_q <= 1'b0;
      end
    end
  end

  logic              span_s, span_d;
  logic [ADDR_W-1:0] stride, y_off;

  assign span_s = act_q.ctrl[CB_SPAN_SRC];
  assign span_d = act_q.ctrl[CB_SPAN_DST];
  assign stride = ADDR_W'(SPAN_STRIDE);
  assign y_off  = ADDR_W'(y_q) + ADDR_W'(1);

  always_comb begin
    if (row_end) begin
      src_d = span_s ? ADDR_W'(act_q.src) + y_off : src_q + ADDR_W'(1);
      dst_d = span_d ? ADDR_W'(act_q.dst) + y_off : dst_q + ADDR_W'(1);
    end else begin
      src_d = src_q + (span_s ? stride : ADDR_W'(1));
      dst_d = dst_q + (span_d ? stride : ADDR_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      act_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (en_e_n) begin
        if (launch) act_q <= pend_q;
        unique case (state_q)
          ST_IDLE: if (launch) state_q <= ST_WAIT_HALT;
          ST_WAIT_HALT: if (halt_ack) begin
            src_q   <= ADDR_W'(act_q.src);
            dst_q   <= ADDR_W'(act_q.dst);
            x_q     <= '0;
            y_q     <= '0;
            state_q <= ST_SRC;
          end
          ST_SRC: if (blt_ack) state_q <= ST_DST;
          ST_DST: if (blt_ack) begin
            src_q <= src_d;
            dst_q <= dst_d;
            if (!row_end) begin
              x_q     <= x_q + 8'd1;
              state_q <= ST_SRC;
            end else begin
              x_q <= '0;
              y_q <= y_q + 8'd1;
              if (last_row) begin
                done_q  <= !abort;
                state_q <= launch ? ST_WAIT_HALT : ST_IDLE;
              end else begin
                state_q <= ST_SRC;
              end
            end
          end
        endcase
        if (abort) state_q <= ST_IDLE;
      end
    end
  end

  williams_blt_pixel_path #(
    .PIX_PER_WORD(PIX_PER_WORD)
  ) u_pix (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (en_e_n),
    .load_i      (state_q == ST_SRC && blt_ack),
    .clr_i       ((state_q == ST_WAIT_HALT && halt_ack) ||
                  (state_q == ST_DST && blt_ack && row_end)),
    .shift_i     (act_q.ctrl[CB_SHIFT]),
    .solid_en_i  (act_q.ctrl[CB_SOLID]),
    .fg_i        (act_q.ctrl[CB_FG]),
    .mask_even_i (act_q.ctrl[CB_MASK_EVEN]),
    .mask_odd_i  (act_q.ctrl[CB_MASK_ODD]),
    .halt_ack_i  (halt_ack),
    .src_i       (state_q == ST_SRC),
    .solid_i     (act_q.solid),
    .key_i       (act_q.key),
    .data_i      (blt_data_in),
    .data_o      (blt_data_out),
    .nib_en_o    (blt_nibble_en)
  );

  always_comb begin
    reg_data_out = '0;
    if (reg_cs && !reg_wr) begin
      if (rs == RS_STATUS)
        reg_data_out = {5'b0, ovf_q, pend_v_q, halt};
      else if (rs == RS_KEY)
        reg_data_out = {4'h0, shd_q.key};
    end
  end

  assign halt            = state_q != ST_IDLE;
  assign blt_rd          = state_q == ST_SRC;
  assign blt_wr          = state_q == ST_DST;
  assign blt_address_out = blt_wr ? dst_q : src_q;
  assign done            = done_q;

endmodule

// File: tb/tb_williams_blitter_q.sv
// Bench for williams_blitter_q: directed and random blits against a
// pixel-level reference model; bus slave with random ack stalls.
module tb_williams_blitter_q;

  logic        clk = 1'b0;
  logic        rst_n, en_e_n, reg_cs, reg_wr;
  logic [3:0]  rs;
  logic [7:0]  reg_data_in, reg_data_out;
  logic        halt, halt_ack, blt_ack, blt_rd, blt_wr, done;
  logic [15:0] blt_address_out;
  logic [7:0]  blt_data_in, blt_data_out;
  logic [1:0]  blt_nibble_en;

  williams_blitter_q dut (
    .clk(clk), .rst_n(rst_n), .en_e_n(en_e_n),
    .reg_cs(reg_cs), .reg_wr(reg_wr), .rs(rs),
    .reg_data_in(reg_data_in), .reg_data_out(reg_data_out),
    .halt(halt), .halt_ack(halt_ack), .blt_ack(blt_ack),
    .blt_rd(blt_rd), .blt_wr(blt_wr),
    .blt_address_out(blt_address_out),
    .blt_data_in(blt_data_in), .blt_data_out(blt_data_out),
    .blt_nibble_en(blt_nibble_en), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned a;
    logic [7:0]  d;
    logic [1:0]  n;
    bit          wr;
  } txn_t;

  txn_t act_q[$];
  txn_t exp_q[$];
  logic [7:0] mem [65536];
  int n_cmp = 0, n_err = 0;
  int ndone = 0, ndrop = 0;
  bit prev_halt = 0, rnd_en = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic wr_reg(input logic [3:0] r, input logic [7:0] v);
    en_e_n = 1; blt_ack = 0; reg_cs = 1; reg_wr = 1;
    rs = r; reg_data_in = v;
    @(posedge clk); #1;
    reg_cs = 0; reg_wr = 0;
  endtask

  task automatic rd_chk(input logic [3:0] r, input logic [7:0] want,
                        input string tag);
    en_e_n = 1; blt_ack = 0; reg_cs = 1; reg_wr = 0; rs = r;
    #1 chk(tag, reg_data_out, want);
    @(posedge clk); #1;
    reg_cs = 0;
  endtask

  // w/h are the effective sizes; the SC1 XOR is undone here
  task automatic prog(input logic [7:0] ctrl, solid,
                      input logic [15:0] src, dst,
                      input logic [7:0] w, h, input logic [3:0] key);
    wr_reg(1, solid);
    wr_reg(2, src[15:8]); wr_reg(3, src[7:0]);
    wr_reg(4, dst[15:8]); wr_reg(5, dst[7:0]);
    wr_reg(6, w ^ 8'h04); wr_reg(7, h ^ 8'h04);
    wr_reg(9, {4'h0, key});
    wr_reg(0, ctrl);
  endtask

  function automatic int unsigned addr_of(input int unsigned base,
      input bit span, input int w, input int x, input int y);
    int unsigned a;
    a = span ? base + y + x * 256 : base + y * w + x;
    return a & 32'hFFFF;
  endfunction

  task automatic model(input logic [7:0] ctrl, solid,
                       input logic [15:0] src, dst,
                       input logic [7:0] w, h, input logic [3:0] key);
    int wd, ht;
    wd = (w == 0) ? 256 : int'(w);
    ht = (h == 0) ? 256 : int'(h);
    for (int y = 0; y < ht; y++) begin
      for (int x = 0; x < wd; x++) begin
        int unsigned sa, da;
        logic [15:0] pair;
        logic [7:0]  d;
        logic [1:0]  n;
        sa = addr_of(src, ctrl[0], wd, x, y);
        da = addr_of(dst, ctrl[1], wd, x, y);
        // row stream slides right by one pixel, zero fill at row start
        pair = {(x == 0) ? 8'h00 : mem[addr_of(src, ctrl[0], wd, x-1, y)],
                mem[sa]};
        if (ctrl[4])      d = solid;
        else if (ctrl[5]) d = pair[11:4];
        else              d = mem[sa];
        for (int i = 0; i < 2; i++)
          n[i] = !(ctrl[6+i] || (ctrl[3] && d[4*i +: 4] == key));
        exp_q.push_back('{a: sa, d: 8'h00, n: 2'b00, wr: 0});
        exp_q.push_back('{a: da, d: d, n: n, wr: 1});
      end
    end
  endtask

  task automatic bus_cycle();
    halt_ack    = halt;
    blt_ack     = ($urandom % 4) != 0;
    en_e_n      = rnd_en ? (($urandom % 8) != 0) : 1'b1;
    blt_data_in = mem[blt_address_out];
    #1;
    if (en_e_n && blt_ack && (blt_rd || blt_wr))
      act_q.push_back('{a: blt_address_out,
                        d: blt_wr ? blt_data_out : 8'h00,
                        n: blt_wr ? blt_nibble_en : 2'b00,
                        wr: blt_wr});
    @(posedge clk); #1;
    if (done) ndone++;
    if (prev_halt && !halt) ndrop++;
    prev_halt = halt;
  endtask

  task automatic clr_cnt();
    ndone = 0; ndrop = 0; prev_halt = halt;
  endtask

  task automatic run_idle(input int budget, input string tag);
    int  n;
    bit  seen;
    n = 0; seen = 0;
    while (n < budget) begin
      bus_cycle(); n++;
      if (halt) seen = 1;
      else if (seen) break;
    end
    chk({tag, "_in_budget"}, 32'(n < budget), 32'd1);
  endtask

  task automatic compare(input string tag);
    chk({tag, "_len"}, act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      chk({tag, "_rw"}, 32'(act_q[i].wr), 32'(exp_q[i].wr));
      chk({tag, "_addr"}, act_q[i].a, exp_q[i].a);
      if (exp_q[i].wr) begin
        chk({tag, "_data"}, act_q[i].d, exp_q[i].d);
        chk({tag, "_nib"}, act_q[i].n, exp_q[i].n);
      end
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic blit(input logic [7:0] ctrl, solid,
                      input logic [15:0] src, dst,
                      input logic [7:0] w, h, input logic [3:0] key,
                      input string tag);
    clr_cnt();
    model(ctrl, solid, src, dst, w, h, key);
    prog(ctrl, solid, src, dst, w, h, key);
    run_idle(6000, tag);
    compare(tag);
    chk({tag, "_done"}, ndone, 1);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    rst_n = 0; en_e_n = 1; reg_cs = 0; reg_wr = 0; rs = 4'd8;
    reg_data_in = 0; halt_ack = 0; blt_ack = 0; blt_data_in = 0;
    #12;
    chk("rst_halt", halt, 0);
    chk("rst_strobes", {blt_rd, blt_wr}, 0);
    chk("rst_done", done, 0);
    chk("rst_nib", blt_nibble_en, 2'b11);
    reg_cs = 1;
    #1 chk("rst_rdata", reg_data_out, 0);
    reg_cs = 0;
    @(posedge clk); #1;
    rst_n = 1;

    blit(8'h10, 8'hAA, 16'h0000, 16'h1000, 8'd2, 8'd1, 4'h0, "fill");

    blit(8'h03, 8'h00, 16'h0100, 16'h2000, 8'd2, 8'd2, 4'h0, "span");

    mem[16'h0500] = 8'h12;
    mem[16'h0501] = 8'h34;
    blit(8'h28, 8'h00, 16'h0500, 16'h3000, 8'd2, 8'd1, 4'h3, "shkey");
    rd_chk(9, 8'h03, "key_rd");

    blit(8'h00, 8'h00, 16'h4000, 16'hFF80, 8'd0, 8'd1, 4'h0, "wrap");

    rnd_en = 1;
    for (int k = 0; k < 6; k++)
      blit(8'($urandom), 8'($urandom), 16'($urandom), 16'($urandom),
           8'($urandom_range(1, 4)), 8'($urandom_range(1, 3)),
           4'($urandom), "rand");
    rnd_en = 0;

    // queue: A runs, B waits, C overflows
    clr_cnt();
    model(8'h00, 8'h00, 16'h0600, 16'h5000, 8'd3, 8'd2, 4'h0);
    prog(8'h00, 8'h00, 16'h0600, 16'h5000, 8'd3, 8'd2, 4'h0);
    for (int i = 0; i < 4; i++) bus_cycle();
    model(8'h02, 8'h00, 16'h0700, 16'h6000, 8'd2, 8'd2, 4'h0);
    prog(8'h02, 8'h00, 16'h0700, 16'h6000, 8'd2, 8'd2, 4'h0);
    wr_reg(0, 8'h10);
    rd_chk(8, 8'h07, "q_stat_ovf");
    rd_chk(8, 8'h03, "q_stat_clr");
    run_idle(6000, "queue");
    compare("queue");
    chk("q_done", ndone, 2);
    chk("q_halt_held", ndrop, 1);
    for (int i = 0; i < 6; i++) bus_cycle();
    chk("q_c_dropped", act_q.size(), 0);
    rd_chk(8, 8'h00, "q_stat_end");

    // abort mid-row with a pending command
    clr_cnt();
    prog(8'h00, 8'h00, 16'h0800, 16'h7000, 8'd4, 8'd2, 4'h0);
    for (int i = 0; i < 7; i++) bus_cycle();
    prog(8'h00, 8'h00, 16'h0900, 16'h7100, 8'd2, 8'd2, 4'h0);
    wr_reg(10, 8'h00);
    chk("abort_halt", halt, 0);
    chk("abort_strobes", {blt_rd, blt_wr}, 0);
    rd_chk(8, 8'h00, "abort_stat");
    for (int i = 0; i < 6; i++) bus_cycle();
    chk("abort_no_done", ndone, 0);
    chk("abort_idle", halt, 0);
    act_q.delete();

    // asynchronous reset mid-blit
    prog(8'h00, 8'h00, 16'h0A00, 16'h7200, 8'd4, 8'd2, 4'h5);
    for (int i = 0; i < 7; i++) bus_cycle();
    #2 rst_n = 0;
    #1;
    chk("areset_halt", halt, 0);
    chk("areset_strobes", {blt_rd, blt_wr}, 0);
    chk("areset_done", done, 0);
    @(posedge clk); #1;
    rst_n = 1;
    rd_chk(8, 8'h00, "areset_stat");
    rd_chk(9, 8'h00, "areset_key");
    chk("areset_no_done", ndone, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
